csr_exec_ctrl: RTL and testbench

Sequencer for the CSR execution path of the out-of-order core. Accepts CSR micro-ops issued by the CSR reservation station into a small FIFO. Holds each op until it is the oldest in-flight instruction, so CSR side effects are never speculative. Then runs the read-modify-write on the CSR register file and broadcasts the old CSR value on the writeback bus for wakeup and ROB completion.

---
 rtl/csr_exec_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_csr_exec_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exec_ctrl.sv
// csr_exec_ctrl: holds issued CSR micro-ops until they reach the ROB head, then runs the
// read-modify-write and broadcasts the old value. Optional wb handshake: CSR_WB_ACK_EN.
module csr_exec_ctrl #(
  parameter int QDEPTH = 4,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_issue_valid,
  output logic              o_issue_ready,
  input  logic [31:0]       i_issue_inst_num,
  input  logic [7:0]        i_issue_rd,
  input  logic [3:0]        i_issue_op,
  input  logic [31:0]       i_issue_src,
  input  logic [CSR_AW-1:0] i_issue_csr_addr,
  input  logic [31:0]       i_rob_head_inst_num,
  input  logic              i_flush,
  output logic              o_csr_rd_en,
  output logic              o_csr_wr_en,
  output logic [CSR_AW-1:0] o_csr_addr,
  output logic [31:0]       o_csr_wdata,
  input  logic [31:0]       i_csr_rdata,
  output logic              o_wb_valid,
  output logic [7:0]        o_wb_rd,
  output logic [31:0]       o_wb_data,
  output logic [31:0]       o_wb_inst_num,
  input  logic              i_wb_ack,
  output logic              o_busy
);

  localparam int          PW      = $clog2(QDEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(QDEPTH);
  localparam logic [PW:0] ZERO_C  = {(PW+1){1'b0}};
  localparam logic [PW:0] ONE_C   = {{PW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HEAD = 3'd1,
    S_READ      = 3'd2,
    S_WRITE     = 3'd3,
    S_WB        = 3'd4
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_rptr;
  logic [PW-1:0]     r_wptr;
  logic [PW:0]       r_count;
  logic [31:0]       r_old_val;

  logic [31:0]       r_q_inst [QDEPTH];
  logic [7:0]        r_q_rd   [QDEPTH];
  logic [3:0]        r_q_op   [QDEPTH];
  logic [31:0]       r_q_src  [QDEPTH];
  logic [CSR_AW-1:0] r_q_addr [QDEPTH];

  logic              w_push;
  logic              w_pop;
  logic              w_keep_head;
  logic [31:0]       w_h_inst;
  logic [7:0]        w_h_rd;
  logic [3:0]        w_h_op;
  logic [31:0]       w_h_src;
  logic [CSR_AW-1:0] w_h_addr;

  function automatic logic f_is_legal(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (op == 4'd3);
  endfunction

  // Set/clear with a zero mask leaves the CSR untouched, so no write strobe is issued.
  function automatic logic f_wr_en(input logic [3:0] op, input logic [31:0] src);
    case (op)
      4'd1:       return 1'b1;
      4'd2, 4'd3: return (src != 32'd0);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [3:0] op, input logic [31:0] old,
                                          input logic [31:0] src);
    case (op)
      4'd1:    return src;
      4'd2:    return old | src;
      4'd3:    return old & ~src;
      default: return old;
    endcase
  endfunction

  assign w_h_inst    = r_q_inst[r_rptr];
  assign w_h_rd      = r_q_rd[r_rptr];
  assign w_h_op      = r_q_op[r_rptr];
  assign w_h_src     = r_q_src[r_rptr];
  assign w_h_addr    = r_q_addr[r_rptr];

  assign o_issue_ready = (r_count < DEPTH_C);
  assign o_busy        = (r_count != ZERO_C) || (r_state != S_IDLE);
  assign w_push        = i_issue_valid && o_issue_ready && !i_flush;
  assign w_keep_head   = (r_state == S_WRITE) || (r_state == S_WB);
`ifdef CSR_WB_ACK_EN
  assign w_pop         = (r_state == S_WB) && i_wb_ack;
`else
  assign w_pop         = (r_state == S_WB) && (i_wb_ack || 1'b1);
`endif

  // Issue FIFO storage, written only on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wptr] <= i_issue_inst_num;
      r_q_rd[r_wptr]   <= i_issue_rd;
      r_q_op[r_wptr]   <= i_issue_op;
      r_q_src[r_wptr]  <= i_issue_src;
      r_q_addr[r_wptr] <= i_issue_csr_addr;
    end
  end

  // FIFO pointers; the in-flight op stays at the head until its writeback exits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= {PW{1'b0}};
      r_wptr  <= {PW{1'b0}};
      r_count <= ZERO_C;
    end else if (i_flush) begin
      if (w_keep_head) begin
        r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
        r_wptr  <= r_rptr + 1'b1;
        r_count <= w_pop ? ZERO_C : ONE_C;
      end else begin
        r_wptr  <= r_rptr;
        r_count <= ZERO_C;
      end
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer FSM with registered strobes and writeback fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_old_val     <= 32'd0;
      o_csr_rd_en   <= 1'b0;
      o_csr_wr_en   <= 1'b0;
      o_csr_addr    <= {CSR_AW{1'b0}};
      o_csr_wdata   <= 32'd0;
      o_wb_valid    <= 1'b0;
      o_wb_rd       <= 8'd0;
      o_wb_data     <= 32'd0;
      o_wb_inst_num <= 32'd0;
    end else begin
      o_csr_rd_en <= 1'b0;
      o_csr_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_wb_valid <= 1'b0;
          if (!i_flush && ((r_count != ZERO_C) || w_push)) r_state <= S_WAIT_HEAD;
          else r_state <= S_IDLE;
        end
        S_WAIT_HEAD: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else if (w_h_inst == i_rob_head_inst_num) begin
            r_state     <= S_READ;
            o_csr_rd_en <= 1'b1;
            o_csr_addr  <= w_h_addr;
          end else begin
            r_state <= S_WAIT_HEAD;
          end
        end
        S_READ: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_state     <= S_WRITE;
            r_old_val   <= i_csr_rdata;
            o_csr_wr_en <= f_wr_en(w_h_op, w_h_src);
            o_csr_wdata <= f_wdata(w_h_op, i_csr_rdata, w_h_src);
          end
        end
        S_WRITE: begin
          r_state       <= S_WB;
          o_wb_valid    <= 1'b1;
          o_wb_rd       <= w_h_rd;
          o_wb_inst_num <= w_h_inst;
          o_wb_data     <= f_is_legal(w_h_op) ? r_old_val : 32'd0;
        end
        S_WB: begin
          if (w_pop) begin
            r_state    <= S_IDLE;
            o_wb_valid <= 1'b0;
          end else begin
            r_state    <= S_WB;
            o_wb_valid <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          o_wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_exec_ctrl.sv
// Self-checking bench for csr_exec_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-timeline model.
module tb_csr_exec_ctrl;
  localparam int QDEPTH = 4;
  localparam int CSR_AW = 12;
`ifdef CSR_WB_ACK_EN
  localparam bit ACK_MODE = 1'b1;
`else
  localparam bit ACK_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic issue_valid, issue_ready, flush, wb_ack, busy;
  logic [31:0] issue_inst_num, issue_src, rob_head_inst_num;
  logic [7:0]  issue_rd;
  logic [3:0]  issue_op;
  logic [CSR_AW-1:0] issue_csr_addr, csr_addr;
  logic csr_rd_en, csr_wr_en, wb_valid;
  logic [31:0] csr_wdata, csr_rdata, wb_data, wb_inst_num;
  logic [7:0]  wb_rd;

  logic [31:0] csr_mem [4096];
  logic [31:0] ref_csr [4096];

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  rd;
    logic [3:0]  op;
    logic [31:0] src;
    logic [11:0] addr;
    int          enq;
  } op_t;

  op_t         mq[$];
  int          h_rd   = -1;
  int          free_c = -100;
  int          cyc    = 0;
  logic [31:0] m_old  = 32'd0;
  int          n_cmp  = 0;
  int          n_bad  = 0;

  always #5 clk = ~clk;

  assign csr_rdata = csr_mem[csr_addr];

  csr_exec_ctrl #(.QDEPTH(QDEPTH), .CSR_AW(CSR_AW)) dut (
    .clk(clk), .reset(reset),
    .i_issue_valid(issue_valid), .o_issue_ready(issue_ready),
    .i_issue_inst_num(issue_inst_num), .i_issue_rd(issue_rd), .i_issue_op(issue_op),
    .i_issue_src(issue_src), .i_issue_csr_addr(issue_csr_addr),
    .i_rob_head_inst_num(rob_head_inst_num), .i_flush(flush),
    .o_csr_rd_en(csr_rd_en), .o_csr_wr_en(csr_wr_en), .o_csr_addr(csr_addr),
    .o_csr_wdata(csr_wdata), .i_csr_rdata(csr_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_wb_inst_num(wb_inst_num), .i_wb_ack(wb_ack), .o_busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] csr_result(input logic [3:0] op, input logic [31:0] old,
                                             input logic [31:0] src);
    if (op == 4'd1) return src;
    if (op == 4'd2) return old | src;
    if (op == 4'd3) return old & ~src;
    return old;
  endfunction

  function automatic bit modifies(input logic [3:0] op, input logic [31:0] src);
    return (op == 4'd1) || (((op == 4'd2) || (op == 4'd3)) && (src != 32'd0));
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] inst, input logic [3:0] op,
                      input logic [31:0] src, input logic [11:0] addr,
                      input logic [31:0] rob, input logic fl, input logic ack);
    op_t h, k;
    bit  has_h, e_rd, e_wr, e_wb, in_rw, acc, pop;
    int  sz, st;
    logic [31:0] e_wdata;
    issue_valid = v; issue_inst_num = inst; issue_rd = inst[7:0] ^ 8'h5A;
    issue_op = op; issue_src = src; issue_csr_addr = addr;
    rob_head_inst_num = rob; flush = fl; wb_ack = ack;
    #1;
    sz    = mq.size();
    has_h = (h_rd >= 0);
    if (sz > 0) h = mq[0];
    e_rd  = has_h && (cyc == h_rd);
    e_wr  = has_h && (cyc == h_rd + 1) && modifies(h.op, h.src);
    e_wb  = has_h && (ACK_MODE ? (cyc >= h_rd + 2) : (cyc == h_rd + 2));
    chk("issue_ready", 32'(issue_ready), 32'(sz < QDEPTH));
    chk("busy", 32'(busy), 32'(sz != 0));
    chk("csr_rd_en", 32'(csr_rd_en), 32'(e_rd));
    if (e_rd) begin
      chk("rd_addr", 32'(csr_addr), 32'(h.addr));
      m_old = ref_csr[h.addr];
    end
    chk("csr_wr_en", 32'(csr_wr_en), 32'(e_wr));
    if (e_wr) begin
      e_wdata = csr_result(h.op, m_old, h.src);
      chk("wr_addr", 32'(csr_addr), 32'(h.addr));
      chk("csr_wdata", csr_wdata, e_wdata);
      ref_csr[h.addr] = e_wdata;
    end
    chk("wb_valid", 32'(wb_valid), 32'(e_wb));
    if (e_wb) begin
      chk("wb_rd", 32'(wb_rd), 32'(h.rd));
      chk("wb_inst_num", wb_inst_num, h.inst);
      chk("wb_data", wb_data, (h.op >= 4'd1 && h.op <= 4'd3) ? m_old : 32'd0);
    end
    // model advance
    in_rw = has_h && (cyc >= h_rd + 1);
    acc   = v && !fl && (sz < QDEPTH);
    pop   = e_wb && (!ACK_MODE || ack);
    if (sz > 0 && !has_h && !fl) begin
      st = mq[0].enq + 1;
      if (free_c + 1 > st) st = free_c + 1;
      if (cyc >= st && rob == mq[0].inst) h_rd = cyc + 1;
    end
    if (fl) begin
      if (in_rw) begin
        k = mq[0]; mq.delete(); mq.push_back(k);
      end else begin
        mq.delete(); h_rd = -1; free_c = cyc + 1;
      end
    end
    if (pop) begin
      void'(mq.pop_front()); h_rd = -1; free_c = cyc + 1;
    end
    if (acc) begin
      k.inst = inst; k.rd = inst[7:0] ^ 8'h5A; k.op = op; k.src = src; k.addr = addr; k.enq = cyc;
      mq.push_back(k);
    end
    if (csr_wr_en) csr_mem[csr_addr] = csr_wdata;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic [31:0] rob);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 32'd0, 12'd0, rob, 1'b0, 1'b1);
  endtask

  task automatic enq(input logic [31:0] inst, input logic [3:0] op, input logic [31:0] src,
                     input logic [11:0] addr, input logic [31:0] rob);
    step(1'b1, inst, op, src, addr, rob, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] rob, inst_ctr;
    reset = 1'b1; issue_valid = 1'b0; issue_inst_num = 32'd0; issue_rd = 8'd0;
    issue_op = 4'd0; issue_src = 32'd0; issue_csr_addr = 12'd0;
    rob_head_inst_num = 32'd0; flush = 1'b0; wb_ack = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = $urandom; ref_csr[i] = csr_mem[i];
    end
    csr_mem[12'h300] = 32'h0000_1234; ref_csr[12'h300] = 32'h0000_1234;
    csr_mem[12'h301] = 32'hA5A5_0001; ref_csr[12'h301] = 32'hA5A5_0001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(csr_rd_en), 32'd0);
    chk("rst_wr_en", 32'(csr_wr_en), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_csr_addr", 32'(csr_addr), 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    reset = 1'b0;
    idle(2, 32'd0);

    // CSRRW best-case latency
    enq(32'd5, 4'd1, 32'hDEAD_BEEF, 12'h300, 32'd5);
    idle(1, 32'd5);
    chk("t1_rd_en", 32'(csr_rd_en), 32'd1);
    chk("t1_addr", 32'(csr_addr), 32'h300);
    idle(1, 32'd5);
    chk("t1_wr_en", 32'(csr_wr_en), 32'd1);
    chk("t1_wdata", csr_wdata, 32'hDEAD_BEEF);
    idle(1, 32'd5);
    chk("t1_wb_valid", 32'(wb_valid), 32'd1);
    chk("t1_wb_data", wb_data, 32'h0000_1234);
    chk("t1_wb_inst", wb_inst_num, 32'd5);
    idle(2, 32'd0);

    // CSRRS with zero mask, stalled at ROB head for 10 cycles
    enq(32'd6, 4'd2, 32'd0, 12'h301, 32'd99);
    for (int i = 0; i < 10; i++) begin
      idle(1, 32'd99);
      chk("t2_stall_rd_en", 32'(csr_rd_en), 32'd0);
    end
    idle(1, 32'd6);
    chk("t2_rd_en", 32'(csr_rd_en), 32'd1);
    idle(1, 32'd6);
    chk("t2_no_write", 32'(csr_wr_en), 32'd0);
    idle(1, 32'd6);
    chk("t2_wb_valid", 32'(wb_valid), 32'd1);
    chk("t2_wb_data", wb_data, 32'hA5A5_0001);
    idle(2, 32'd0);

    // Fill past capacity, then drain in order
    for (int i = 0; i < 4; i++) enq(32'd10 + 32'(i), 4'd1, $urandom, 12'h302, 32'd99);
    chk("t3_full_ready", 32'(issue_ready), 32'd0);
    enq(32'd14, 4'd1, 32'd7, 12'h302, 32'd99);
    for (int k = 0; k < 4; k++) begin
      idle(3, 32'd10 + 32'(k));
      chk("t3_wb_order", wb_inst_num, 32'd10 + 32'(k));
      idle(2, 32'd10 + 32'(k));
    end
    chk("t3_drained_busy", 32'(busy), 32'd0);

    // Flush while reading: nothing completes
    for (int i = 0; i < 3; i++) enq(32'd20 + 32'(i), 4'd1, 32'h55, 12'h304, 32'd99);
    idle(1, 32'd20);
    chk("t4_rd_en", 32'(csr_rd_en), 32'd1);
    step(1'b0, 32'd0, 4'd0, 32'd0, 12'd0, 32'd20, 1'b1, 1'b1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_no_write", 32'(csr_wr_en), 32'd0);
    idle(3, 32'd20);

    // Flush while writing: in-flight op completes, others dropped
    for (int i = 0; i < 3; i++) enq(32'd30 + 32'(i), 4'd1, 32'h77, 12'h305, 32'd99);
    idle(2, 32'd30);
    chk("t5_wr_en", 32'(csr_wr_en), 32'd1);
    step(1'b0, 32'd0, 4'd0, 32'd0, 12'd0, 32'd31, 1'b1, 1'b1);
    chk("t5_wb_valid", 32'(wb_valid), 32'd1);
    chk("t5_wb_inst", wb_inst_num, 32'd30);
    idle(1, 32'd31);
    chk("t5_busy", 32'(busy), 32'd0);
    idle(3, 32'd31);

    // Illegal op: read only, zero writeback data
    enq(32'd40, 4'd7, 32'hFFFF_FFFF, 12'h306, 32'd40);
    idle(1, 32'd40);
    chk("t6_rd_en", 32'(csr_rd_en), 32'd1);
    idle(1, 32'd40);
    chk("t6_no_write", 32'(csr_wr_en), 32'd0);
    idle(1, 32'd40);
    chk("t6_wb_valid", 32'(wb_valid), 32'd1);
    chk("t6_wb_data", wb_data, 32'd0);
    idle(2, 32'd0);

`ifdef CSR_WB_ACK_EN
    // Writeback held until acknowledged
    enq(32'd50, 4'd2, 32'd1, 12'h303, 32'd50);
    idle(3, 32'd50);
    chk("t7_wb_valid", 32'(wb_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 4'd0, 32'd0, 12'd0, 32'd50, 1'b0, 1'b0);
      chk("t7_wb_hold", 32'(wb_valid), 32'd1);
      chk("t7_wb_inst_hold", wb_inst_num, 32'd50);
    end
    idle(1, 32'd50);
    chk("t7_busy", 32'(busy), 32'd0);
`endif

    // Randomized traffic
    inst_ctr = 32'd1000;
    for (int i = 0; i < 1500; i++) begin
      logic v;
      logic [3:0] op;
      logic [31:0] src;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 2) != 0) rob = mq[0].inst;
        else rob = mq[$urandom_range(0, mq.size() - 1)].inst;
      end else begin
        rob = $urandom;
      end
      v   = ($urandom_range(0, 1) == 1);
      op  = 4'($urandom_range(0, 5));
      src = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      step(v, inst_ctr, op, src, 12'h300 + 12'($urandom_range(0, 7)), rob,
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 1) == 1));
      if (v) inst_ctr = inst_ctr + 32'd1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
